mem_store_buffer: RTL and testbench
===================================

# mem_store_buffer

Parametrised write-buffer FIFO between the 6502 core's bus interface and the BRAM/vector-memory write ports. It captures one store per rising edge of the core's write strobe and drains entries in order whenever the memory side grants a write slot. It is the successor to the fixed 32×8-bit store queue and adds configurable widths and depth, correct simultaneous push/pop, store-to-load forwarding, flush, and overflow reporting.

## Interface
Parameters:
- DATA_W, 8, store data width in bits
- ADDR_W, 16, store address width in bits
- DEPTH, 32, number of entries; power of 2, at least 2
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; not overridden)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- we  input  1  core write strobe; one store per 0→1 transition
- addr  input  ADDR_W  core store address, sampled on the accepted edge
- D  input  DATA_W  core store data, sampled on the accepted edge
- flush  input  1  synchronous discard of all queued entries
- wr_ready  input  1  memory side can accept a write this cycle
- wr_valid  output  1  head entry present (queue not empty)
- wr_fire  output  1  wr_valid && wr_ready; memory commits the head this cycle
- Q  output  DATA_W  head entry data
- writeAddr  output  ADDR_W  head entry address
- rd_addr  input  ADDR_W  load-lookup address from the core
- fwd_hit  output  1  a queued entry matches rd_addr
- fwd_data  output  DATA_W  data of the youngest matching entry; 0 when there is no hit
- count  output  CNT_W  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  sticky flag: a store was dropped
- clear_ovf  input  1  clears overflow

## Operation
- State: data/addr arrays, head pointer, tail pointer, count, we_q (previous we), overflow.
- push = we && !we_q && !flush.
- pop = wr_fire && !flush.
- Accept rule: the push is accepted if !full, or if full and pop in the same cycle.
- Push writes D and addr at the tail and advances the tail. Pop advances the head.
- Count update: push-only +1, pop-only −1, push+pop unchanged.
- Pointers wrap modulo DEPTH with natural log2 wrap.
- Empty and push in the same cycle: no pop occurs, because wr_valid is low. The entry appears at the head next cycle.
- Dropped push (full, no pop): data is discarded and overflow is set. If clear_ovf is asserted in the same cycle as a drop, the set wins.
- flush: count is cleared to 0 and head = tail. A coincident push or pop is ignored. we_q still tracks we, so a held strobe does not re-push after the flush.
- Forwarding is combinational over the valid entries (head through tail−1). On multiple matches, the youngest (closest to tail) wins. A push in the current cycle is not visible to the lookup.
- Q and writeAddr are undefined when empty. The bench must not check them in that case.

## Timing
- Reset values: all pointers, count, we_q and overflow are 0. Outputs after reset: wr_valid=0, wr_fire=0, empty=1, full=0, fwd_hit=0, fwd_data=0, count=0. Array contents are not reset.
- Latency from a we rise at edge N: wr_valid=1 and the data on Q after edge N. The earliest wr_fire is in the cycle following edge N.
- Throughput is one push and one pop per cycle. A new push needs we to deassert for at least one cycle.
- rst_n is asynchronous mid-operation: the queue empties immediately and no write is issued afterwards.

## Structure
- Package core_if_pkg holds the default DATA_W/ADDR_W, the BRAM select constants, and the memory-map address constants shared with the address decoder.
- Sub-module store_fwd_match: a parameterised youngest-match priority selector. Inputs: valid mask, addr array, tail, rd_addr. Outputs: hit, index.
- The parent holds the storage, pointers, counters and flags.

## Test plan
- Reset and drain, DEPTH=4: push A=0x2000/0x11 and B=0x2001/0x22 with wr_ready=0, then raise wr_ready → wr_fire in 2 consecutive cycles, Q=0x11 then 0x22, count 2→1→0, empty=1.
- Fill and overflow: 5 pushes with wr_ready=0 → full=1 after the 4th, overflow=1 after the 5th, count=4. Draining yields the first 4 values in order. clear_ovf → overflow=0.
- Simultaneous push and pop at full, with wr_ready=1 and a we rise in the same cycle → count stays 4, overflow stays 0, the new entry is drained last.
- Forwarding: queue 0x0100/0xAA then 0x0100/0xBB; rd_addr=0x0100 → fwd_hit=1, fwd_data=0xBB. rd_addr=0x0101 → fwd_hit=0, fwd_data=0.
- Edge detection and flush: hold we high 5 cycles → count=1. Assert flush with we still high → count=0 next cycle and no re-push. Asserting rst_n low mid-queue → empty=1 immediately.

Source files
------------

// File: rtl/core_if_pkg.sv
// Shared 6502 core-interface definitions: default bus widths, BRAM selects and
// the memory map used by both the store buffer and the address decoder.
package core_if_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 16;

  typedef enum logic [1:0] {
    BRAM_SEL_MAIN = 2'd0,
    BRAM_SEL_VEC  = 2'd1,
    BRAM_SEL_IO   = 2'd2,
    BRAM_SEL_NONE = 2'd3
  } bram_sel_e;

  localparam logic [15:0] MAP_ZP_BASE    = 16'h0000;
  localparam logic [15:0] MAP_STACK_BASE = 16'h0100;
  localparam logic [15:0] MAP_RAM_TOP    = 16'h7FFF;
  localparam logic [15:0] MAP_VEC_BASE   = 16'h8000;
  localparam logic [15:0] MAP_VEC_TOP    = 16'hBFFF;
  localparam logic [15:0] MAP_IO_BASE    = 16'hC000;
  localparam logic [15:0] MAP_IO_TOP     = 16'hCFFF;

  // Everything above the I/O window is ROM and has no writable BRAM behind it.
  function automatic bram_sel_e decode_bram_sel(input logic [15:0] a);
    if (a <= MAP_RAM_TOP)                         return BRAM_SEL_MAIN;
    else if (a >= MAP_VEC_BASE && a <= MAP_VEC_TOP) return BRAM_SEL_VEC;
    else if (a >= MAP_IO_BASE && a <= MAP_IO_TOP)   return BRAM_SEL_IO;
    else                                            return BRAM_SEL_NONE;
  endfunction

endpackage

// File: rtl/store_fwd_match.sv
// Youngest-match selector for store-to-load forwarding: among valid entries
// whose address equals rd_addr, picks the one written most recently.
module store_fwd_match #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 16,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr_array,
  input  logic [PTR_W-1:0]             tail,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         hit,
  output logic [PTR_W-1:0]             index
);

  logic [DEPTH-1:0] match;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid[gi] && (addr_array[gi] == rd_addr);
    end
  endgenerate

  // Walk from oldest (tail-DEPTH) to youngest (tail-1); the last match wins.
  logic [PTR_W-1:0] idx;
  always_comb begin
    hit   = 1'b0;
    index = '0;
    idx   = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PTR_W'(k);
      if (match[idx]) begin
        hit   = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/mem_store_buffer.sv
// Write-buffer FIFO between the 6502 bus interface and the BRAM write ports,
// with edge-triggered capture, in-order drain, forwarding, flush and overflow.
module mem_store_buffer
  import core_if_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] D,
  input  logic              flush,
  input  logic              wr_ready,
  output logic              wr_valid,
  output logic              wr_fire,
  output logic [DATA_W-1:0] Q,
  output logic [ADDR_W-1:0] writeAddr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              clear_ovf
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]             data_mem [DEPTH];
  logic [DEPTH-1:0][ADDR_W-1:0]  addr_mem;

  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic             we_q_reg;
  logic             overflow_reg;

  logic push, pop, accept, drop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign wr_valid = !empty;
  assign wr_fire  = wr_valid && wr_ready;
  assign count    = count_reg;
  assign overflow = overflow_reg;

  assign push   = we && !we_q_reg && !flush;
  assign pop    = wr_fire && !flush;
  // A full queue still takes a store when the head leaves in the same cycle.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  assign Q         = data_mem[head_reg];
  assign writeAddr = addr_mem[head_reg];

  always_ff @(posedge clk) begin
    if (accept) begin
      data_mem[tail_reg] <= D;
      addr_mem[tail_reg] <= addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      we_q_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      we_q_reg <= we;
      if (flush) begin
        head_reg  <= tail_reg;
        count_reg <= '0;
      end else begin
        if (accept) tail_reg <= tail_reg + PTR_W'(1);
        if (pop)    head_reg <= head_reg + PTR_W'(1);
        if (accept && !pop)      count_reg <= count_reg + CNT_W'(1);
        else if (pop && !accept) count_reg <= count_reg - CNT_W'(1);
      end
      if (drop)           overflow_reg <= 1'b1;
      else if (clear_ovf) overflow_reg <= 1'b0;
    end
  end

  // Entry i is live when its distance from head is below the occupancy.
  logic [DEPTH-1:0] valid;
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      logic [PTR_W-1:0] offset;
      assign offset    = PTR_W'(gi) - head_reg;
      assign valid[gi] = (CNT_W'(offset) < count_reg);
    end
  endgenerate

  logic [PTR_W-1:0] fwd_index;

  store_fwd_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PTR_W  (PTR_W)
  ) u_fwd_match (
    .valid      (valid),
    .addr_array (addr_mem),
    .tail       (tail_reg),
    .rd_addr    (rd_addr),
    .hit        (fwd_hit),
    .index      (fwd_index)
  );

  assign fwd_data = fwd_hit ? data_mem[fwd_index] : '0;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer (DEPTH=4): table-driven fill/drain
// rows plus hand sequences, with a scoreboard queue checking drain order.
module tb_mem_store_buffer;

  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] d_in = '0;
  logic          flush = 1'b0;
  logic          wr_ready = 1'b0;
  logic          wr_valid, wr_fire;
  logic [DW-1:0] q_out;
  logic [AW-1:0] write_addr;
  logic [AW-1:0] rd_addr = '0;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [CW-1:0] count;
  logic          full, empty, overflow;
  logic          clear_ovf = 1'b0;

  mem_store_buffer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .addr      (addr),
    .D         (d_in),
    .flush     (flush),
    .wr_ready  (wr_ready),
    .wr_valid  (wr_valid),
    .wr_fire   (wr_fire),
    .Q         (q_out),
    .writeAddr (write_addr),
    .rd_addr   (rd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } entry_t;

  entry_t exp_q[$];
  logic   m_we_q = 1'b0;
  logic   m_ovf  = 1'b0;

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          rdy;
    logic          clr;
    int            cnt;
    logic          ovf;
  } row_t;

  row_t rows[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input int we_i, input int a_i, input int d_i,
                              input int rdy_i, input int clr_i, input int cnt_i,
                              input int ovf_i);
    row_t r;
    r.we  = we_i[0];
    r.a   = a_i[AW-1:0];
    r.d   = d_i[DW-1:0];
    r.rdy = rdy_i[0];
    r.clr = clr_i[0];
    r.cnt = cnt_i;
    r.ovf = ovf_i[0];
    rows.push_back(r);
  endfunction

  // One clock with inputs already driven: check the drain side before the
  // edge, advance the reference model, then land on the next falling edge.
  task automatic tick();
    int   sz;
    logic exp_fire, m_pop, m_push, m_drop;
    entry_t e;
    #1;
    sz       = exp_q.size();
    exp_fire = rst_n && (sz > 0) && wr_ready;
    chk("wr_fire", {31'd0, wr_fire}, {31'd0, exp_fire});
    if (exp_fire) begin
      e = exp_q[0];
      chk("head_data", {24'd0, q_out}, {24'd0, e.d});
      chk("head_addr", {16'd0, write_addr}, {16'd0, e.a});
      $display("pop addr=%h data=%h", write_addr, q_out);
    end
    m_pop  = exp_fire && !flush;
    m_push = rst_n && we && !m_we_q && !flush;
    m_drop = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_we_q = 1'b0;
    end else begin
      if (flush) exp_q.delete();
      else begin
        if (m_pop) void'(exp_q.pop_front());
        if (m_push) begin
          if (sz < DEPTH || m_pop) begin
            e.a = addr;
            e.d = d_in;
            exp_q.push_back(e);
          end else m_drop = 1'b1;
        end
      end
      if (m_drop) m_ovf = 1'b1;
      else if (clear_ovf) m_ovf = 1'b0;
      m_we_q = we;
    end
    @(posedge clk);
    @(negedge clk);
    chk("model_count", {29'd0, count}, exp_q.size());
    chk("model_ovf", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  initial begin
    // Stimulus table: drain of two, fill/overflow/drain/clear, push+pop at full.
    add(1, 'h2000, 'h11, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0);
    add(1, 'h2001, 'h22, 0, 0, 2, 0);
    add(0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      add(1, 'h3000 + i, 'h31 + i, 0, 0, (i < 4) ? i + 1 : 4, (i == 4) ? 1 : 0);
      add(0, 0, 0, 0, 0, (i < 4) ? i + 1 : 4, (i == 4) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 0, 3 - i, 1);
    add(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      add(1, 'h4000 + i, 'h41 + i, 0, 0, i + 1, 0);
      add(0, 0, 0, 0, 0, i + 1, 0);
    end
    add(1, 'h4004, 'h45, 1, 0, 4, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 0, 3 - i, 0);

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_wr_valid", {31'd0, wr_valid}, 0);
    chk("rst_wr_fire", {31'd0, wr_fire}, 0);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_fwd_hit", {31'd0, fwd_hit}, 0);
    chk("rst_fwd_data", {24'd0, fwd_data}, 0);
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (rows[i]) begin
      we        = rows[i].we;
      addr      = rows[i].a;
      d_in      = rows[i].d;
      wr_ready  = rows[i].rdy;
      clear_ovf = rows[i].clr;
      tick();
      chk("row_count", {29'd0, count}, rows[i].cnt);
      chk("row_full", {31'd0, full}, (rows[i].cnt == DEPTH) ? 1 : 0);
      chk("row_empty", {31'd0, empty}, (rows[i].cnt == 0) ? 1 : 0);
      chk("row_wr_valid", {31'd0, wr_valid}, (rows[i].cnt != 0) ? 1 : 0);
      chk("row_overflow", {31'd0, overflow}, {31'd0, rows[i].ovf});
      $display("row %0d we=%0b rdy=%0b count=%0d ovf=%0b", i, rows[i].we, rows[i].rdy, count, overflow);
    end
    we = 1'b0; wr_ready = 1'b0; clear_ovf = 1'b0;

    // Forwarding: youngest of two same-address stores wins
    we = 1'b1; addr = 16'h0100; d_in = 8'hAA; tick();
    we = 1'b0; tick();
    we = 1'b1; addr = 16'h0100; d_in = 8'hBB; tick();
    we = 1'b0; tick();
    we = 1'b1; addr = 16'h0200; d_in = 8'hCC; tick();
    we = 1'b0; tick();
    rd_addr = 16'h0100; #1;
    chk("fwd_hit_0100", {31'd0, fwd_hit}, 1);
    chk("fwd_data_0100", {24'd0, fwd_data}, 32'hBB);
    rd_addr = 16'h0101; #1;
    chk("fwd_hit_0101", {31'd0, fwd_hit}, 0);
    chk("fwd_data_0101", {24'd0, fwd_data}, 0);
    rd_addr = 16'h0200; #1;
    chk("fwd_data_0200", {24'd0, fwd_data}, 32'hCC);
    @(negedge clk);
    rd_addr = 16'h0300; we = 1'b1; addr = 16'h0300; d_in = 8'hDD; #1;
    chk("fwd_same_cycle_push", {31'd0, fwd_hit}, 0);
    tick();
    chk("fwd_hit_0300", {31'd0, fwd_hit}, 1);
    chk("fwd_data_0300", {24'd0, fwd_data}, 32'hDD);
    $display("fwd rd_addr=%h hit=%0b data=%h", rd_addr, fwd_hit, fwd_data);
    we = 1'b0; wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    wr_ready = 1'b0;
    chk("fwd_drained_empty", {31'd0, empty}, 1);

    // Held strobe pushes once; flush with strobe still high does not re-push
    we = 1'b1; addr = 16'h5000; d_in = 8'h55;
    for (int i = 0; i < 5; i++) tick();
    chk("held_we_count", {29'd0, count}, 1);
    flush = 1'b1; tick();
    chk("flush_count", {29'd0, count}, 0);
    flush = 1'b0; tick();
    chk("post_flush_no_repush", {29'd0, count}, 0);
    $display("flush count=%0d", count);
    we = 1'b0; tick();

    // Asynchronous reset mid-queue
    we = 1'b1; addr = 16'h6000; d_in = 8'h66; tick();
    we = 1'b0; tick();
    we = 1'b1; addr = 16'h6001; d_in = 8'h67; tick();
    we = 1'b0; tick();
    chk("pre_reset_count", {29'd0, count}, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_empty", {31'd0, empty}, 1);
    chk("async_rst_count", {29'd0, count}, 0);
    chk("async_rst_wr_valid", {31'd0, wr_valid}, 0);
    $display("async reset empty=%0b count=%0d", empty, count);
    @(negedge clk);
    wr_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_empty", {31'd0, empty}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
